// File: rtl/link_arb_types_pkg.sv
// Arbiter state encoding and requester-index helpers for link_tx_arbiter.
package link_arb_types;
    typedef enum logic {IDLE, LOCKED} arb_state_t;

    // Keeps a one-bit index legal when there is only one requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_REQUESTERS_DEFAULT = 3;
    typedef logic [idx_width(NUM_REQUESTERS_DEFAULT)-1:0] req_idx_t;
endpackage

// File: rtl/types_pkg.sv
// Shared link-layer types used across the NoC.
package types;
    typedef logic [31:0] flit_t;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker with an optional strict-priority override for index 0.
module rr_priority_picker
    import link_arb_types::*;
#(
    parameter int NUM_REQUESTERS = 3,
    localparam int IDX_W = idx_width(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] valid,
    input  logic [IDX_W-1:0]          rr_ptr,
    input  logic                      strict_prio0,
    output logic [IDX_W-1:0]          grant,
    output logic                      found
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        if (strict_prio0 && valid[0]) begin
            found = 1'b1;
        end else begin
            // Scan starts one past the last winner so it becomes lowest priority.
            for (int k = 1; k <= NUM_REQUESTERS; k++) begin
                cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQUESTERS);
                if (!found && valid[cand]) begin
                    found = 1'b1;
                    grant = cand;
                end
            end
        end
    end

endmodule

// File: rtl/link_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding the outbound link through a one-entry register.
// Optional stall watchdog enabled by defining LINK_ARB_WATCHDOG_EN.
module link_tx_arbiter
    import link_arb_types::*;
#(
    parameter int NUM_REQUESTERS   = 3,
    parameter int REQ0_STRICT_PRIO = 1,
    parameter int MAX_STALL_CYCLES = 64
) (
    input  logic                                 nocclk,
    input  logic                                 rst_n,
    input  types::flit_t [NUM_REQUESTERS-1:0]    req_flit,
    input  logic [NUM_REQUESTERS-1:0]            req_last,
    input  logic [NUM_REQUESTERS-1:0]            req_valid,
    output logic [NUM_REQUESTERS-1:0]            req_ready,
    output types::flit_t                         out_flit,
    output logic                                 out_last,
    output logic [idx_width(NUM_REQUESTERS)-1:0] out_src,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 stall_abort
);

    localparam int IDX_W = idx_width(NUM_REQUESTERS);
    typedef logic [IDX_W-1:0] idx_t;

    arb_state_t state_q, state_d;
    idx_t       rr_ptr_q, rr_ptr_d, held_q, held_d;
    idx_t       pick_grant, grant;
    logic       pick_found, grant_found;
    logic       load_en, accept, abort;

    assign load_en = !out_valid || out_ready;

    rr_priority_picker #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_picker (
        .valid        (req_valid),
        .rr_ptr       (rr_ptr_q),
        .strict_prio0 (REQ0_STRICT_PRIO != 0),
        .grant        (pick_grant),
        .found        (pick_found)
    );

    // A locked packet owns the link until its tail, even through bubbles.
    always_comb begin
        grant       = pick_grant;
        grant_found = pick_found;
        if (state_q == LOCKED) begin
            grant       = held_q;
            grant_found = 1'b1;
        end
    end

    assign accept = load_en && grant_found && req_valid[grant];

    always_comb begin
        req_ready = '0;
        if (rst_n && load_en && grant_found) req_ready[grant] = 1'b1;
    end

`ifdef LINK_ARB_WATCHDOG_EN
    localparam int STALL_W = $clog2(MAX_STALL_CYCLES + 1);
    logic [STALL_W-1:0] stall_cnt;
    logic               stalled;

    assign stalled = (state_q == LOCKED) && !req_valid[held_q];
    assign abort   = stalled && (stall_cnt == STALL_W'(MAX_STALL_CYCLES - 1));

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n)                                         stall_cnt <= '0;
        else if ((state_q != LOCKED) || accept || abort)    stall_cnt <= '0;
        else if (stalled)                                   stall_cnt <= stall_cnt + 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = (MAX_STALL_CYCLES == 0);
    assign abort      = 1'b0;
`endif

    assign stall_abort = abort;
    assign busy        = (state_q == LOCKED);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        held_d   = held_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rr_ptr_d = grant;
                    if (!req_last[grant]) begin
                        state_d = LOCKED;
                        held_d  = grant;
                    end
                end
            end
            LOCKED: begin
                if (accept && req_last[held_q]) begin
                    state_d = IDLE;
                end else if (abort) begin
                    // Truncated packet is abandoned; its source yields to the others.
                    state_d  = IDLE;
                    rr_ptr_d = held_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            held_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            held_q   <= held_d;
        end
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (load_en) begin
            out_valid <= accept;
            if (accept) begin
                out_flit <= req_flit[grant];
                out_last <= req_last[grant];
                out_src  <= grant;
            end
        end
    end

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Randomised self-checking bench for link_tx_arbiter against a packet-level reference model.
module tb_link_tx_arbiter;
    import link_arb_types::*;

    localparam int N         = 3;
    localparam int STALL_MAX = 8;
`ifdef LINK_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic nocclk = 1'b0;
    logic rst_n;
    always #5 nocclk = ~nocclk;

    types::flit_t [N-1:0] req_flit;
    logic [N-1:0]         req_last, req_valid;
    logic                 out_ready;

    logic [N-1:0] a_ready, b_ready;
    types::flit_t a_flit, b_flit;
    logic         a_last, b_last, a_valid, b_valid, a_busy, b_busy, a_abort, b_abort;
    logic [1:0]   a_src, b_src;

    // dut_a: strict priority for requester 0; dut_b: plain round-robin
    link_tx_arbiter #(.NUM_REQUESTERS(N), .REQ0_STRICT_PRIO(1), .MAX_STALL_CYCLES(STALL_MAX)) dut_a (
        .nocclk(nocclk), .rst_n(rst_n), .req_flit(req_flit), .req_last(req_last),
        .req_valid(req_valid), .req_ready(a_ready), .out_flit(a_flit), .out_last(a_last),
        .out_src(a_src), .out_valid(a_valid), .out_ready(out_ready), .busy(a_busy),
        .stall_abort(a_abort));

    link_tx_arbiter #(.NUM_REQUESTERS(N), .REQ0_STRICT_PRIO(0), .MAX_STALL_CYCLES(STALL_MAX)) dut_b (
        .nocclk(nocclk), .rst_n(rst_n), .req_flit(req_flit), .req_last(req_last),
        .req_valid(req_valid), .req_ready(b_ready), .out_flit(b_flit), .out_last(b_last),
        .out_src(b_src), .out_valid(b_valid), .out_ready(out_ready), .busy(b_busy),
        .stall_abort(b_abort));

    logic         sel;
    logic [N-1:0] obs_ready;
    types::flit_t obs_flit;
    logic         obs_last, obs_valid, obs_busy, obs_abort;
    logic [1:0]   obs_src;
    assign obs_ready = sel ? b_ready : a_ready;
    assign obs_flit  = sel ? b_flit  : a_flit;
    assign obs_last  = sel ? b_last  : a_last;
    assign obs_src   = sel ? b_src   : a_src;
    assign obs_valid = sel ? b_valid : a_valid;
    assign obs_busy  = sel ? b_busy  : a_busy;
    assign obs_abort = sel ? b_abort : a_abort;

    int n_checks = 0;
    int n_pass   = 0;

    // Source packet storage: bit 32 = tail marker, bits 31:0 = flit.
    logic [32:0]  mem [N][512];
    int           wr_p [N];
    int           rd_p [N];
    logic [N-1:0] en;
    int           pkt_ctr = 0;

    // Reference model of the link-level behaviour.
    int          m_rr, m_owner, m_src, m_stall;
    bit          m_locked, m_ov, m_last;
    logic [31:0] m_flit;

    typedef struct {int cyc; int src; bit last; logic [31:0] flit;} xfer_t;
    xfer_t xfers[$];
    int    heads[$];
    bit    prev_last;
    int    cyc;
    int    obs_abort_cnt;

    function automatic int pick(input logic [N-1:0] v, input int rr, input bit strict);
        if (strict && v[0]) return 0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (rr + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic add_pkt(input int s, input int len);
        for (int f = 0; f < len; f++) begin
            mem[s][wr_p[s]] = {(f == len - 1), 4'(s), 12'(pkt_ctr), 16'(f)};
            wr_p[s]++;
        end
        pkt_ctr++;
    endtask

    task automatic model_reset();
        m_rr = 0; m_owner = 0; m_src = 0; m_stall = 0;
        m_locked = 0; m_ov = 0; m_last = 0; m_flit = '0;
        for (int i = 0; i < N; i++) begin
            wr_p[i] = 0;
            rd_p[i] = 0;
        end
        en = '0;
        xfers.delete();
        heads.delete();
        prev_last = 1'b1;
        cyc = 0;
        obs_abort_cnt = 0;
    endtask

    task automatic do_reset(input logic which);
        @(negedge nocclk);
        sel       = which;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_flit  = '0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge nocclk);
        rst_n = 1'b1;
    endtask

    // One clock of stimulus: drive sources, compare handshakes, advance model, compare outputs.
    task automatic step();
        logic [N-1:0] v, exp_ready;
        bit           load, exp_abort, acc, acc_last;
        int           g;
        for (int i = 0; i < N; i++) begin
            v[i]        = en[i] && (rd_p[i] < wr_p[i]);
            req_flit[i] = v[i] ? mem[i][rd_p[i]][31:0] : '0;
            req_last[i] = v[i] ? mem[i][rd_p[i]][32] : 1'b0;
        end
        req_valid = v;
        #1;
        load = !m_ov || out_ready;
        g    = m_locked ? m_owner : pick(v, m_rr, !sel);
        exp_ready = '0;
        if (load && g >= 0) exp_ready[g] = 1'b1;
        exp_abort = WD && m_locked && !v[m_owner] && (m_stall + 1 == STALL_MAX);

        n_checks++;
        if (obs_ready !== exp_ready) $display("FAIL req_ready cyc %0d: got %b expected %b", cyc, obs_ready, exp_ready);
        else n_pass++;
        n_checks++;
        if (obs_abort !== exp_abort) $display("FAIL stall_abort cyc %0d: got %b expected %b", cyc, obs_abort, exp_abort);
        else n_pass++;

        if (obs_abort === 1'b1) obs_abort_cnt++;
        if (obs_valid === 1'b1 && out_ready) begin
            xfers.push_back('{cyc, int'(obs_src), obs_last, obs_flit});
            if (prev_last) heads.push_back(int'(obs_src));
            prev_last = obs_last;
        end

        acc      = (g >= 0) && load && v[g];
        acc_last = 1'b0;
        @(posedge nocclk);
        if (load) m_ov = acc;
        if (acc) begin
            m_flit   = mem[g][rd_p[g]][31:0];
            acc_last = mem[g][rd_p[g]][32];
            m_last   = acc_last;
            m_src    = g;
            rd_p[g]++;
        end
        if (exp_abort) begin
            m_locked = 0;
            m_rr     = m_owner;
            m_stall  = 0;
        end else if (acc) begin
            m_stall = 0;
            if (!m_locked) begin
                m_rr = g;
                if (!acc_last) begin
                    m_locked = 1;
                    m_owner  = g;
                end
            end else if (acc_last) begin
                m_locked = 0;
            end
        end else if (m_locked && !v[m_owner]) begin
            m_stall++;
        end

        @(negedge nocclk);
        n_checks++;
        if (obs_valid !== m_ov) $display("FAIL out_valid cyc %0d: got %b expected %b", cyc, obs_valid, m_ov);
        else n_pass++;
        if (m_ov) begin
            n_checks++;
            if ({obs_flit, obs_last, 32'(obs_src)} !== {m_flit, m_last, 32'(m_src)})
                $display("FAIL out_data cyc %0d: got %h/%b/%0d expected %h/%b/%0d",
                         cyc, obs_flit, obs_last, obs_src, m_flit, m_last, m_src);
            else n_pass++;
        end
        n_checks++;
        if (obs_busy !== m_locked) $display("FAIL busy cyc %0d: got %b expected %b", cyc, obs_busy, m_locked);
        else n_pass++;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        sel       = 1'b0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        req_valid = '1;
        req_last  = '0;
        req_flit  = '1;
        #3;
        n_checks++;
        if ({obs_valid, obs_last, obs_busy, obs_abort} !== 4'b0) $display("FAIL reset_ctrl: got %b expected 0000", {obs_valid, obs_last, obs_busy, obs_abort});
        else n_pass++;
        n_checks++;
        if ({obs_flit, obs_src} !== '0) $display("FAIL reset_data: got %h/%0d expected 0/0", obs_flit, obs_src);
        else n_pass++;
        n_checks++;
        if (obs_ready !== '0) $display("FAIL reset_ready: got %b expected 000", obs_ready);
        else n_pass++;
    endtask

    task automatic test_single_flit();
        do_reset(1'b0);
        for (int p = 0; p < 5; p++) add_pkt(1, 1);
        en[1] = 1'b1;
        run(8);
        n_checks++;
        if (xfers.size() != 5) $display("FAIL single_flit_count: got %0d expected 5", xfers.size());
        else n_pass++;
    endtask

    task automatic test_concurrent();
        int k;
        do_reset(1'b0);
        add_pkt(1, 4);
        add_pkt(2, 3);
        en[1] = 1'b1;
        run(2);
        en[2] = 1'b1;
        run(8);
        k = -1;
        foreach (xfers[i]) if (k < 0 && xfers[i].src == 1 && xfers[i].last) k = i;
        n_checks++;
        if (k < 0 || k + 1 >= xfers.size()) $display("FAIL concurrent_order: got no req1 tail followed by req2 expected one");
        else if (xfers[k+1].src != 2 || xfers[k+1].cyc != xfers[k].cyc + 1)
            $display("FAIL concurrent_no_bubble: got src %0d gap %0d expected src 2 gap 1", xfers[k+1].src, xfers[k+1].cyc - xfers[k].cyc);
        else n_pass++;
    endtask

    task automatic test_strict();
        do_reset(1'b0);
        add_pkt(0, 1);
        add_pkt(2, 1);
        en[0] = 1'b1;
        en[2] = 1'b1;
        run(4);
        n_checks++;
        if (heads.size() < 2 || heads[0] != 0 || heads[1] != 2) $display("FAIL strict_prio: got %0d heads expected order 0,2", heads.size());
        else n_pass++;
    endtask

    task automatic test_preempt();
        do_reset(1'b0);
        add_pkt(2, 4);
        add_pkt(0, 2);
        en[2] = 1'b1;
        step();
        en[0] = 1'b1;
        run(8);
        n_checks++;
        if (heads.size() != 2 || heads[0] != 2 || heads[1] != 0) $display("FAIL preempt: got %0d heads expected order 2,0", heads.size());
        else n_pass++;
    endtask

    task automatic test_out_ready_stall();
        do_reset(1'b0);
        add_pkt(1, 6);
        en[1] = 1'b1;
        run(3);
        out_ready = 1'b0;
        run(5);
        out_ready = 1'b1;
        run(6);
        n_checks++;
        if (xfers.size() != 6) $display("FAIL stall_count: got %0d expected 6", xfers.size());
        else n_pass++;
        for (int i = 0; i < 6 && i < xfers.size(); i++) begin
            n_checks++;
            if (xfers[i].flit !== mem[1][i][31:0]) $display("FAIL stall_seq %0d: got %h expected %h", i, xfers[i].flit, mem[1][i][31:0]);
            else n_pass++;
        end
    endtask

    task automatic test_rr_order();
        int exp_order [6] = '{1, 2, 0, 1, 2, 0};
        do_reset(1'b1);
        for (int s = 0; s < N; s++) begin
            add_pkt(s, 2);
            add_pkt(s, 2);
        end
        en = '1;
        run(16);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= heads.size()) $display("FAIL rr_order %0d: got none expected %0d", i, exp_order[i]);
            else if (heads[i] != exp_order[i]) $display("FAIL rr_order %0d: got %0d expected %0d", i, heads[i], exp_order[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset(1'b0);
        add_pkt(2, 5);
        en[2] = 1'b1;
        run(3);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({obs_valid, obs_busy} !== 2'b00) $display("FAIL async_reset: got valid/busy %b expected 00", {obs_valid, obs_busy});
        else n_pass++;
        model_reset();
        add_pkt(2, 3);
        en[2] = 1'b1;
        @(negedge nocclk);
        rst_n = 1'b1;
        run(6);
        n_checks++;
        if (xfers.size() != 3 || !xfers[2].last) $display("FAIL restart_pkt: got %0d flits expected 3 ending in tail", xfers.size());
        else n_pass++;
    endtask

    task automatic test_watchdog();
        do_reset(1'b0);
        add_pkt(1, 6);
        add_pkt(2, 1);
        en[1] = 1'b1;
        run(2);
        en[1] = 1'b0;
        en[2] = 1'b1;
        run(20);
        n_checks++;
        if (obs_abort_cnt != (WD ? 1 : 0)) $display("FAIL abort_pulses: got %0d expected %0d", obs_abort_cnt, WD ? 1 : 0);
        else n_pass++;
        if (WD) begin
            rd_p[1] = wr_p[1];
            n_checks++;
            if (heads.size() != 2 || heads[1] != 2) $display("FAIL after_abort: got %0d heads expected req2 second", heads.size());
            else n_pass++;
        end else begin
            n_checks++;
            if (heads.size() != 1) $display("FAIL lock_held: got %0d heads expected 1", heads.size());
            else n_pass++;
            en[1] = 1'b1;
            run(8);
            n_checks++;
            if (heads.size() != 2 || heads[1] != 2) $display("FAIL resume_lock: got %0d heads expected req2 second", heads.size());
            else n_pass++;
        end
    endtask

    task automatic test_random(input logic which);
        do_reset(which);
        for (int c = 0; c < 300; c++) begin
            for (int s = 0; s < N; s++) begin
                if (wr_p[s] - rd_p[s] < 4 && wr_p[s] < 480 && $urandom_range(3) == 0)
                    add_pkt(s, 1 + $urandom_range(3));
                en[s] = ($urandom_range(9) < 8);
            end
            out_ready = ($urandom_range(3) != 0);
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_concurrent();
        test_strict();
        test_preempt();
        test_out_ready_stall();
        test_rr_order();
        test_reset_mid_packet();
        test_watchdog();
        test_random(1'b0);
        test_random(1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
